// File: rtl/item_ram_arbiter_if.sv
// Client and RAM-side signal bundle for the item RAM arbiter.
// The slave modport is the arbiter's view; master is the clients' and RAM's view.
interface item_ram_arbiter_if;
  logic        load_req;
  logic [3:0]  load_addr;
  logic [31:0] load_wdata;
  logic        load_gnt;

  logic        draw_req;
  logic        draw_lock;
  logic [3:0]  draw_addr;
  logic        draw_gnt;
  logic        draw_rvalid;

  logic        rope_req;
  logic        rope_we;
  logic [3:0]  rope_addr;
  logic [31:0] rope_wdata;
  logic        rope_gnt;
  logic        rope_rvalid;

  logic [31:0] rdata;
  logic [3:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic [7:0]  starve_cnt;

  modport slave (
    input  load_req, load_addr, load_wdata,
    input  draw_req, draw_lock, draw_addr,
    input  rope_req, rope_we, rope_addr, rope_wdata,
    input  ram_q,
    output load_gnt, draw_gnt, draw_rvalid, rope_gnt, rope_rvalid,
    output rdata, ram_address, ram_data, ram_wren, starve_cnt
  );

  modport master (
    output load_req, load_addr, load_wdata,
    output draw_req, draw_lock, draw_addr,
    output rope_req, rope_we, rope_addr, rope_wdata,
    output ram_q,
    input  load_gnt, draw_gnt, draw_rvalid, rope_gnt, rope_rvalid,
    input  rdata, ram_address, ram_data, ram_wren, starve_cnt
  );
endinterface

// File: rtl/item_ram_arbiter.sv
// Single-port arbiter for the 16x32 item RAM: loader > renderer > rope, with a
// renderer burst lock and a forced rope slot once the rope has starved long enough.
module item_ram_arbiter #(
  parameter int RAM_LAT      = 1,
  parameter int STARVE_LIMIT = 64
) (
  input logic              clock,
  input logic              reset,
  item_ram_arbiter_if.slave bus
);
  localparam logic [1:0] LAT_LAST   = 2'(RAM_LAT - 1);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_LOAD, OWN_DRAW, OWN_ROPE} owner_t;

  typedef struct packed {
    owner_t      owner;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } acc_t;

  state_t      state, state_nx;
  acc_t        acc, acc_nx;
  logic [1:0]  wait_cnt;
  logic [7:0]  starve;
  logic [31:0] rdata_q;
  logic        draw_rv_q, rope_rv_q;
  logic        in_access, capture, rope_elig;

  assign in_access = (state == S_ACCESS);
  assign capture   = (state == S_WAIT) && (wait_cnt == LAT_LAST);
  // Under draw_lock the rope is eligible only once it has starved long enough.
  assign rope_elig = bus.rope_req && (!bus.draw_lock || (starve >= STARVE_LIM));

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    case (state)
      S_IDLE: begin
        if (bus.load_req) begin
          acc_nx   = '{OWN_LOAD, 1'b1, bus.load_addr, bus.load_wdata};
          state_nx = S_ACCESS;
        end else if (rope_elig && bus.draw_lock) begin
          acc_nx   = '{OWN_ROPE, bus.rope_we, bus.rope_addr, bus.rope_wdata};
          state_nx = S_ACCESS;
        end else if (bus.draw_req) begin
          acc_nx   = '{OWN_DRAW, 1'b0, bus.draw_addr, 32'h0};
          state_nx = S_ACCESS;
        end else if (rope_elig) begin
          acc_nx   = '{OWN_ROPE, bus.rope_we, bus.rope_addr, bus.rope_wdata};
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: state_nx = acc.we ? S_IDLE : S_WAIT;
      S_WAIT:   if (capture) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      wait_cnt  <= 2'd0;
      starve    <= 8'd0;
      rdata_q   <= 32'h0;
      draw_rv_q <= 1'b0;
      rope_rv_q <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      wait_cnt  <= (state == S_WAIT && !capture) ? wait_cnt + 2'd1 : 2'd0;
      draw_rv_q <= capture && (acc.owner == OWN_DRAW);
      rope_rv_q <= capture && (acc.owner == OWN_ROPE);
      if (capture) rdata_q <= bus.ram_q;
      if (!bus.rope_req || bus.rope_gnt) starve <= 8'd0;
      else if (starve != 8'hFF)          starve <= starve + 8'd1;
    end
  end

  assign bus.load_gnt    = in_access && (acc.owner == OWN_LOAD);
  assign bus.draw_gnt    = in_access && (acc.owner == OWN_DRAW);
  assign bus.rope_gnt    = in_access && (acc.owner == OWN_ROPE);
  assign bus.draw_rvalid = draw_rv_q;
  assign bus.rope_rvalid = rope_rv_q;
  assign bus.rdata       = rdata_q;
  assign bus.ram_address = acc.addr;
  assign bus.ram_data    = acc.wdata;
  assign bus.ram_wren    = in_access && acc.we;
  assign bus.starve_cnt  = starve;
endmodule

// File: tb/tb_item_ram_arbiter.sv
// Scoreboard bench for item_ram_arbiter: stimulus pushes hand-timed expected
// grant/rvalid events, a negedge monitor pops and compares every one the DUT shows.
module tb_item_ram_arbiter;
  localparam int RAM_LAT = 1;
  localparam int STARVE_LIMIT = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  item_ram_arbiter_if bus();

  item_ram_arbiter #(.RAM_LAT(RAM_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  // RAM model: write on the address edge; read data appears RAM_LAT edges later.
  logic [31:0] mem [16];
  logic [31:0] qp  [RAM_LAT];
  always @(posedge clock) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    qp[0] <= mem[bus.ram_address];
    for (int k = 1; k < RAM_LAT; k++) qp[k] <= qp[k-1];
  end
  assign bus.ram_q = qp[RAM_LAT-1];

  typedef struct {
    int          cyc;
    logic [2:0]  gnt;   // {load, draw, rope}
    logic [1:0]  rv;    // {draw, rope}
    logic        wren;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input int c, input logic [2:0] g, input logic [1:0] r,
                      input logic w, input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.gnt = g; e.rv = r; e.wren = w; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every cycle with a grant or rvalid must match the next expected event.
  always @(negedge clock) begin
    logic [2:0] g;
    logic [1:0] r;
    exp_t e;
    logic ok;
    g = {bus.load_gnt, bus.draw_gnt, bus.rope_gnt};
    r = {bus.draw_rvalid, bus.rope_rvalid};
    if (|g || |r) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_event: got cyc=%0d gnt=%b rv=%b, expected nothing", cyc, g, r);
      end else begin
        e  = exp_q.pop_front();
        ok = (cyc == e.cyc) && (g == e.gnt) && (r == e.rv);
        if (|g) ok = ok && (bus.ram_wren == e.wren) && (bus.ram_address == e.addr)
                        && (!e.wren || bus.ram_data == e.data);
        if (|r) ok = ok && (bus.rdata == e.data);
        if (!ok) begin
          n_miss++;
          $display("FAIL event: got cyc=%0d gnt=%b rv=%b we=%b a=%0d wd=%h rd=%h, expected cyc=%0d gnt=%b rv=%b we=%b a=%0d d=%h",
                   cyc, g, r, bus.ram_wren, bus.ram_address, bus.ram_data, bus.rdata,
                   e.cyc, e.gnt, e.rv, e.wren, e.addr, e.data);
        end
      end
    end
  end

  task automatic at(input int k);
    while (cyc < k) begin @(posedge clock); #1; end
  endtask

  // Requester: raise request, hold until its grant (bounded), then drop it.
  task automatic issue(input int who, input logic we, input logic [3:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    case (who)
      0: begin bus.load_addr = a; bus.load_wdata = d; bus.load_req = 1'b1; end
      1: begin bus.draw_addr = a; bus.draw_req = 1'b1; end
      default: begin bus.rope_we = we; bus.rope_addr = a; bus.rope_wdata = d; bus.rope_req = 1'b1; end
    endcase
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      got = (who == 0) ? bus.load_gnt : (who == 1) ? bus.draw_gnt : bus.rope_gnt;
    end
    case (who)
      0: bus.load_req = 1'b0;
      1: bus.draw_req = 1'b0;
      default: bus.rope_req = 1'b0;
    endcase
    if (!got) begin
      n_vec++; n_miss++;
      $display("FAIL grant_timeout: requester %0d got no grant, expected one", who);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_flags"}, {26'h0, bus.load_gnt, bus.draw_gnt, bus.rope_gnt,
                         bus.draw_rvalid, bus.rope_rvalid, bus.ram_wren}, 32'h0);
    chk({nm, "_addr"},   {28'h0, bus.ram_address}, 32'h0);
    chk({nm, "_data"},   bus.ram_data, 32'h0);
    chk({nm, "_rdata"},  bus.rdata, 32'h0);
    chk({nm, "_starve"}, {24'h0, bus.starve_cnt}, 32'h0);
  endtask

  int s;

  initial begin
    bus.load_req = 1'b0; bus.load_addr = 4'h0; bus.load_wdata = 32'h0;
    bus.draw_req = 1'b0; bus.draw_lock = 1'b0; bus.draw_addr = 4'h0;
    bus.rope_req = 1'b0; bus.rope_we = 1'b0; bus.rope_addr = 4'h0; bus.rope_wdata = 32'h0;

    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;

    // T1: loader write
    @(posedge clock); #1; s = cyc;
    push(s+1, 3'b100, 2'b00, 1'b1, 4'd3, 32'hA5A5_0003);
    issue(0, 1'b1, 4'd3, 32'hA5A5_0003);
    at(s+4);

    // T2: renderer read of the same entry
    s = cyc;
    push(s+1, 3'b010, 2'b00, 1'b0, 4'd3, 32'h0);
    push(s+3, 3'b000, 2'b10, 1'b0, 4'd0, 32'hA5A5_0003);
    issue(1, 1'b0, 4'd3, 32'h0);
    at(s+5);

    // T3: all three at once -> load, draw, rope
    s = cyc;
    push(s+1, 3'b100, 2'b00, 1'b1, 4'd5, 32'h1111_0005);
    push(s+3, 3'b010, 2'b00, 1'b0, 4'd5, 32'h0);
    push(s+5, 3'b000, 2'b10, 1'b0, 4'd0, 32'h1111_0005);
    push(s+6, 3'b001, 2'b00, 1'b0, 4'd3, 32'h0);
    push(s+8, 3'b000, 2'b01, 1'b0, 4'd0, 32'hA5A5_0003);
    fork
      issue(0, 1'b1, 4'd5, 32'h1111_0005);
      issue(1, 1'b0, 4'd5, 32'h0);
      issue(2, 1'b0, 4'd3, 32'h0);
    join
    at(s+10);

    // T4: draw_lock starves rope until the forced slot
    s = cyc;
    bus.draw_lock = 1'b1;
    push(s+65, 3'b001, 2'b00, 1'b0, 4'd5, 32'h0);
    push(s+67, 3'b000, 2'b01, 1'b0, 4'd0, 32'h1111_0005);
    fork
      issue(2, 1'b0, 4'd5, 32'h0);
      begin
        at(s+64); @(negedge clock);
        chk("starve_at_limit", {24'h0, bus.starve_cnt}, STARVE_LIMIT);
      end
    join
    at(s+66); @(negedge clock);
    chk("starve_cleared", {24'h0, bus.starve_cnt}, 32'h0);
    at(s+68);
    bus.draw_lock = 1'b0;

    // T5: reset during S_WAIT of a rope read aborts it
    @(posedge clock); #1; s = cyc;
    push(s+1, 3'b001, 2'b00, 1'b0, 4'd3, 32'h0);
    issue(2, 1'b0, 4'd3, 32'h0);
    at(s+2); reset = 1'b1;
    at(s+3); reset = 1'b0;
    @(negedge clock);
    chk_reset_outputs("midreset");
    @(posedge clock); #1; s = cyc;
    push(s+1, 3'b001, 2'b00, 1'b1, 4'd7, 32'hDEAD_0007);
    issue(2, 1'b1, 4'd7, 32'hDEAD_0007);
    at(s+3); s = cyc;
    push(s+1, 3'b001, 2'b00, 1'b0, 4'd7, 32'h0);
    push(s+3, 3'b000, 2'b01, 1'b0, 4'd0, 32'hDEAD_0007);
    issue(2, 1'b0, 4'd7, 32'h0);
    at(s+5);

    // T6: rope withdraws while draw is being served
    s = cyc;
    push(s+1, 3'b010, 2'b00, 1'b0, 4'd7, 32'h0);
    push(s+3, 3'b000, 2'b10, 1'b0, 4'd0, 32'hDEAD_0007);
    bus.rope_we = 1'b0; bus.rope_addr = 4'd3; bus.rope_req = 1'b1;
    fork
      issue(1, 1'b0, 4'd7, 32'h0);
      begin at(s+2); bus.rope_req = 1'b0; end
    join
    @(negedge clock);
    chk("starve_while_waiting", {24'h0, bus.starve_cnt}, 32'd2);
    at(s+3); @(negedge clock);
    chk("starve_after_withdraw", {24'h0, bus.starve_cnt}, 32'h0);
    at(s+10);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
